// File: rtl/fpga_cfg_pkg.sv
// Shared configuration constants for the option-pricer FPGA build.
// Holds the parameter word width, CSR framing bytes, register indices and
// the command-decoder state encoding. The PC-side driver mirrors these values.
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;

    // Host framing bytes
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Register indices (ADDR[6:0])
    localparam logic [6:0] IDX_S0     = 7'h00;
    localparam logic [6:0] IDX_R      = 7'h01;
    localparam logic [6:0] IDX_SIGMA  = 7'h02;
    localparam logic [6:0] IDX_T      = 7'h03;
    localparam logic [6:0] IDX_STRIKE = 7'h04;
    localparam logic [6:0] IDX_DISC   = 7'h05;
    localparam logic [6:0] IDX_NPATHS = 7'h06;
    localparam logic [6:0] IDX_SEED   = 7'h07;
    localparam logic [6:0] IDX_CMD    = 7'h0F;
    localparam int         NUM_PARAMS = 8;

    typedef enum logic [2:0] {
        CSR_HUNT,
        CSR_ADDR,
        CSR_DATA,
        CSR_CHK,
        CSR_RESP
    } csr_state_t;

endpackage

// File: rtl/param_csr_decoder.sv
// Framed-command decoder: parses SYNC/ADDR/data/CHK frames from the UART
// bridge into the pricing parameter registers and issues the run strobe.
// Ports: clk/rst; rx_* byte sink (registered rx_ready); tx_* response source;
// busy from the datapath; parameter register outputs; start and frame_err pulses.
// Latency: writes, start and the first response byte appear the cycle after
// the CHK byte is accepted. Backpressure: rx_ready is low while a response is
// pending; tx_data holds until tx_ready.
module param_csr_decoder
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH       = FP_WIDTH,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    input  logic             busy,
    output logic [WIDTH-1:0] s0,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] sigma,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] strike,
    output logic [WIDTH-1:0] disc,
    output logic [WIDTH-1:0] n_paths,
    output logic [WIDTH-1:0] seed,
    output logic             start,
    output logic             frame_err
);

    localparam int NB  = WIDTH / 8;
    localparam int BCW = $clog2(NB + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    csr_state_t       state_q;
    logic             rx_ready_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;
    logic             start_q;
    logic             ferr_q;
    logic [7:0]       addr_q;
    logic [WIDTH-1:0] data_q;
    logic [7:0]       chk_q;
    logic [BCW-1:0]   bcnt_q;
    logic [BCW-1:0]   remain_q;     // read-data bytes still to send after current one
    logic [WIDTH-1:0] rd_q;         // read shadow, shifted out MSB first
    logic [TCW-1:0]   idle_q;
    logic [WIDTH-1:0] regs_q [NUM_PARAMS];

    logic       rx_acc;
    logic       tx_acc;
    logic       in_frame;
    logic       timeout;
    logic [6:0] idx;
    logic       is_param;
    logic       wr_en_d;
    logic       rd_en_d;
    logic       start_d;
    logic       ferr_d;
    logic [7:0] resp_d;

    assign rx_acc   = rx_valid && rx_ready_q;
    assign tx_acc   = tx_valid_q && tx_ready;
    assign in_frame = (state_q == CSR_ADDR) || (state_q == CSR_DATA) || (state_q == CSR_CHK);
    assign timeout  = in_frame && !rx_acc && (idle_q == TCW'(TIMEOUT_CYC - 1));
    assign idx      = addr_q[6:0];
    assign is_param = idx < 7'(NUM_PARAMS);

    // Frame verdict, only consumed when the CHK byte is accepted.
    always_comb begin
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        start_d = 1'b0;
        ferr_d  = 1'b0;
        resp_d  = NAK_BYTE;
        if (rx_data != chk_q) begin
            ferr_d = 1'b1;
        end else if (addr_q[7]) begin
            if (is_param) begin
                rd_en_d = 1'b1;
                resp_d  = ACK_BYTE;
            end
        end else if (is_param) begin
            // Parameters are frozen while a run is in progress.
            if (!busy) begin
                wr_en_d = 1'b1;
                resp_d  = ACK_BYTE;
            end
        end else if (idx == IDX_CMD) begin
            if (data_q[0] && !busy && (regs_q[3'(IDX_NPATHS)] != '0)) begin
                start_d = 1'b1;
                resp_d  = ACK_BYTE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CSR_HUNT;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            start_q    <= 1'b0;
            ferr_q     <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= '0;
            chk_q      <= 8'h00;
            bcnt_q     <= '0;
            remain_q   <= '0;
            rd_q       <= '0;
            idle_q     <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) regs_q[i] <= '0;
        end else begin
            start_q <= 1'b0;
            ferr_q  <= 1'b0;

            if (in_frame && !rx_acc && !timeout) idle_q <= idle_q + 1'b1;
            else                                 idle_q <= '0;

            if (timeout) begin
                // Partial frame abandoned silently apart from the error pulse.
                state_q    <= CSR_HUNT;
                rx_ready_q <= 1'b1;
                ferr_q     <= 1'b1;
            end else begin
                case (state_q)
                    CSR_HUNT: begin
                        rx_ready_q <= 1'b1;
                        if (rx_acc && rx_data == SYNC_BYTE) state_q <= CSR_ADDR;
                    end
                    CSR_ADDR: if (rx_acc) begin
                        addr_q  <= rx_data;
                        chk_q   <= rx_data;
                        bcnt_q  <= '0;
                        state_q <= CSR_DATA;
                    end
                    CSR_DATA: if (rx_acc) begin
                        // SYNC here is plain data: no resync inside a frame.
                        data_q <= (data_q << 8) | WIDTH'(rx_data);
                        chk_q  <= chk_q ^ rx_data;
                        if (bcnt_q == BCW'(NB - 1)) state_q <= CSR_CHK;
                        else                        bcnt_q  <= bcnt_q + 1'b1;
                    end
                    CSR_CHK: if (rx_acc) begin
                        if (wr_en_d) regs_q[idx[2:0]] <= data_q;
                        start_q    <= start_d;
                        ferr_q     <= ferr_d;
                        rd_q       <= regs_q[idx[2:0]];
                        remain_q   <= rd_en_d ? BCW'(NB) : '0;
                        tx_data_q  <= resp_d;
                        tx_valid_q <= 1'b1;
                        rx_ready_q <= 1'b0;
                        state_q    <= CSR_RESP;
                    end
                    CSR_RESP: if (tx_acc) begin
                        if (remain_q == '0) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= CSR_HUNT;
                        end else begin
                            tx_data_q <= rd_q[WIDTH-1 -: 8];
                            rd_q      <= rd_q << 8;
                            remain_q  <= remain_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= CSR_HUNT;
                        rx_ready_q <= 1'b1;
                        tx_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign start     = start_q;
    assign frame_err = ferr_q;
    assign s0        = regs_q[3'(IDX_S0)];
    assign r         = regs_q[3'(IDX_R)];
    assign sigma     = regs_q[3'(IDX_SIGMA)];
    assign t         = regs_q[3'(IDX_T)];
    assign strike    = regs_q[3'(IDX_STRIKE)];
    assign disc      = regs_q[3'(IDX_DISC)];
    assign n_paths   = regs_q[3'(IDX_NPATHS)];
    assign seed      = regs_q[3'(IDX_SEED)];

endmodule

// File: tb/tb_param_csr_decoder.sv
// Bench for param_csr_decoder: directed frames, expected response bytes
// queued by the stimulus and consumed by an independent TX monitor.
module tb_param_csr_decoder;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        busy = 1'b0;
    logic [31:0] s0, r, sigma, t, strike, disc, n_paths, seed;
    logic        start, frame_err;

    int total = 0;
    int bad = 0;
    int start_cyc = 0;
    int ferr_cyc = 0;
    logic [7:0] exp_q[$];

    param_csr_decoder #(.WIDTH(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy),
        .s0(s0), .r(r), .sigma(sigma), .t(t), .strike(strike), .disc(disc),
        .n_paths(n_paths), .seed(seed),
        .start(start), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // TX monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst) begin
            if (start)     start_cyc++;
            if (frame_err) ferr_cyc++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL rx_accept_timeout: got no accept expected byte %h taken", b);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        send_byte(c);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push5(input logic [7:0] a, b, c, d, e);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        exp_q.push_back(d); exp_q.push_back(e);
    endtask

    initial begin
        int sc, fc, viol;

        // Reset state
        #12;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_strike", strike, 0);
        chk("rst_pulses", {start, frame_err}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rx_ready_after_rst", rx_ready, 1);

        // Write strike; effect visible the cycle after CHK accept
        exp_q.push_back(8'h06);
        send_frame(8'h04, 32'h0064_0000, 8'h60);
        chk("wr_strike_now", strike, 32'h0064_0000);
        chk("tx_valid_now", tx_valid, 1);
        drain("wr_strike_resp");
        chk("wr_strike_ferr", ferr_cyc, 0);

        // Read strike
        push5(8'h06, 8'h00, 8'h64, 8'h00, 8'h00);
        send_frame(8'h84, 32'h0, 8'h84);
        drain("rd_strike_resp");

        // Bad checksum
        exp_q.push_back(8'h15);
        send_frame(8'h01, 32'h1234_5678, 8'h00);
        drain("badchk_resp");
        chk("badchk_r", r, 0);
        chk("badchk_ferr", ferr_cyc, 1);

        // Start gating: n_paths == 0
        exp_q.push_back(8'h15);
        send_frame(8'h0F, 32'h1, 8'h0E);
        drain("cmd_np0_resp");
        chk("cmd_np0_start", start_cyc, 0);

        // n_paths = 1000, then start
        exp_q.push_back(8'h06);
        send_frame(8'h06, 32'h0000_03E8, 8'hED);
        drain("wr_np_resp");
        chk("wr_np_val", n_paths, 32'd1000);
        exp_q.push_back(8'h06);
        send_frame(8'h0F, 32'h1, 8'h0E);
        drain("cmd_go_resp");
        chk("cmd_go_start", start_cyc, 1);

        // Busy: start refused, writes refused, reads allowed
        busy = 1'b1;
        exp_q.push_back(8'h15);
        send_frame(8'h0F, 32'h1, 8'h0E);
        drain("cmd_busy_resp");
        chk("cmd_busy_start", start_cyc, 1);
        exp_q.push_back(8'h15);
        send_frame(8'h00, 32'h0000_0007, 8'h07);
        drain("wr_busy_resp");
        chk("wr_busy_s0", s0, 0);
        push5(8'h06, 8'h00, 8'h00, 8'h03, 8'hE8);
        send_frame(8'h86, 32'h0, 8'h86);
        drain("rd_busy_resp");
        busy = 1'b0;

        // Unknown index write, CMD read
        exp_q.push_back(8'h15);
        send_frame(8'h10, 32'h0, 8'h10);
        drain("unk_resp");
        exp_q.push_back(8'h15);
        send_frame(8'h8F, 32'h0, 8'h8F);
        drain("rd_cmd_resp");

        // Timeout on a partial frame
        fc = ferr_cyc;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (TO - 10) @(negedge clk);
        chk("to_early", ferr_cyc, fc);
        repeat (30) @(negedge clk);
        chk("to_ferr", ferr_cyc, fc + 1);
        chk("to_no_tx", tx_valid, 0);
        @(posedge clk); #1;
        exp_q.push_back(8'h06);
        send_frame(8'h02, 32'h1122_3344, 8'h46);
        drain("to_next_resp");
        chk("to_next_sigma", sigma, 32'h1122_3344);

        // Backpressure during a read
        tx_ready = 1'b0;
        push5(8'h06, 8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(8'h82, 32'h0, 8'h82);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_data !== 8'h06 || rx_ready !== 1'b0 || tx_valid !== 1'b1) viol++;
        end
        chk("bp_hold", viol, 0);
        tx_ready = 1'b1;
        drain("bp_resp");

        // Reset mid-read
        tx_ready = 1'b0;
        sc = start_cyc;
        push5(8'h06, 8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(8'h82, 32'h0, 8'h82);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_regs", sigma | strike | n_paths, 0);
        exp_q.delete();
        tx_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rx_ready_up", rx_ready, 1);
        chk("midrst_no_start", start_cyc, sc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
